// File: rtl/interrupt_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interrupt_controller: edge-latched, masked, lowest-index-first requester |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module interrupt_controller #(
  parameter int N_SRC = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ie_set,
  input  logic             ie_clr,
  input  logic             inta,
  input  logic             iret,
  output logic             intp,
  output logic [VEC_W-1:0] vector,
  output logic             in_service,
  output logic [N_SRC-1:0] pending,
  output logic             ie
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_SRC-1:0] irq_q, irq_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             ie_q, ie_d;
  logic             intp_q, intp_d;
  logic             in_service_q, in_service_d;
  logic [VEC_W-1:0] vector_q, vector_d;

  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] eligible;
  logic [VEC_W-1:0] sel_idx;
  logic             fire;
  logic             ack;
  logic             ret;

  always_comb begin
    edges    = irq_in & ~irq_q;
    eligible = pending_q & mask_q;
    fire     = (state_q == ST_IDLE) && ie_q && (|eligible);
    ack      = (state_q == ST_REQ) && inta;
    ret      = (state_q == ST_SERVICE) && iret;
  end

  // Scan from the top so the final assignment is the lowest eligible index.
  always_comb begin
    sel_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = VEC_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (fire) state_d = ST_REQ;
      ST_REQ:     if (ack)  state_d = ST_SERVICE;
      ST_SERVICE: if (ret)  state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    intp_d       = intp_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    irq_d        = irq_in;
    mask_d       = mask_we ? mask_wdata : mask_q;

    if (fire) begin
      intp_d   = 1'b1;
      vector_d = sel_idx;
    end
    if (ack) begin
      intp_d       = 1'b0;
      in_service_d = 1'b1;
    end
    if (ret) in_service_d = 1'b0;

    // A fresh edge on the source being acknowledged must survive the clear.
    pending_d = pending_q;
    if (ack) pending_d[vector_q] = 1'b0;
    pending_d = pending_d | edges;

    ie_d = ie_q;
    if (ie_set) ie_d = 1'b1;
    if (ret)    ie_d = 1'b1;
    if (ack)    ie_d = 1'b0;
    if (ie_clr) ie_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      ie_q         <= 1'b0;
      intp_q       <= 1'b0;
      vector_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      irq_q        <= irq_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      ie_q         <= ie_d;
      intp_q       <= intp_d;
      vector_q     <= vector_d;
      in_service_q <= in_service_d;
    end
  end

  assign intp       = intp_q;
  assign vector     = vector_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign ie         = ie_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_interrupt_controller: directed scenarios plus random vs. ref model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_interrupt_controller;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ie_set;
  logic       ie_clr;
  logic       inta;
  logic       iret;
  logic       intp;
  logic [2:0] vector;
  logic       in_service;
  logic [7:0] pending;
  logic       ie;

  int total = 0;
  int bad   = 0;

  // Reference model: the request/service status is carried by the visible
  // outputs themselves (a request is outstanding while m_intp, service while m_insvc).
  logic       m_intp, m_insvc, m_ie;
  logic [2:0] m_vec;
  logic [7:0] m_pending, m_mask, m_prev;

  logic [13:0] obs;
  logic [13:0] exp_v;
  assign obs = {intp, vector, in_service, ie, pending};

  interrupt_controller #(.N_SRC(8), .VEC_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ie_set     (ie_set),
    .ie_clr     (ie_clr),
    .inta       (inta),
    .iret       (iret),
    .intp       (intp),
    .vector     (vector),
    .in_service (in_service),
    .pending    (pending),
    .ie         (ie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] st(input int i, input int v, input int s, input int e, input int p);
    return {i[0], v[2:0], s[0], e[0], p[7:0]};
  endfunction

  task automatic model_step();
    logic [7:0] edges, elig, np;
    logic       ack, ret, nie;
    if (rst) begin
      m_prev = '0; m_pending = '0; m_mask = '0; m_ie = 1'b0;
      m_intp = 1'b0; m_vec = '0; m_insvc = 1'b0;
    end else begin
      edges = irq_in & ~m_prev;
      elig  = m_pending & m_mask;
      ack   = m_intp & inta;
      ret   = m_insvc & iret;
      np = m_pending;
      if (ack) np[m_vec] = 1'b0;
      np = np | edges;
      nie = m_ie;
      if (ie_set) nie = 1'b1;
      if (ret)    nie = 1'b1;
      if (ack)    nie = 1'b0;
      if (ie_clr) nie = 1'b0;
      if (!m_intp && !m_insvc && m_ie && elig != 0) begin
        m_intp = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (elig[i]) begin m_vec = 3'(i); break; end
        end
      end else if (ack) begin
        m_intp = 1'b0; m_insvc = 1'b1;
      end else if (ret) begin
        m_insvc = 1'b0;
      end
      m_pending = np;
      m_ie      = nie;
      m_prev    = irq_in;
      if (mask_we) m_mask = mask_wdata;
    end
  endtask

  // One clock: advance the model with the current inputs, clock the DUT,
  // then drop all single-cycle strobes.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    mask_we = 1'b0; ie_set = 1'b0; ie_clr = 1'b0; inta = 1'b0; iret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = '0;
    cycle(); cycle();
    rst = 1'b0;
    total++; if (intp !== 1'b0) begin bad++; $display("FAIL reset.intp got=%b want=0", intp); end
    total++; if (vector !== 3'd0) begin bad++; $display("FAIL reset.vector got=%0d want=0", vector); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL reset.in_service got=%b want=0", in_service); end
    total++; if (pending !== 8'h00) begin bad++; $display("FAIL reset.pending got=%h want=00", pending); end
    total++; if (ie !== 1'b0) begin bad++; $display("FAIL reset.ie got=%b want=0", ie); end
  endtask

  task automatic test_single();
    mask_we = 1'b1; mask_wdata = 8'hFF; ie_set = 1'b1; cycle();
    exp_v = st(0,0,0,1,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL single.setup got=%h want=%h", obs, exp_v); end
    irq_in = 8'h20; cycle();
    exp_v = st(0,0,0,1,'h20); total++; if (obs !== exp_v) begin bad++; $display("FAIL single.pending got=%h want=%h", obs, exp_v); end
    irq_in = 8'h00; cycle();
    exp_v = st(1,5,0,1,'h20); total++; if (obs !== exp_v) begin bad++; $display("FAIL single.req got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle();
    exp_v = st(0,5,1,0,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL single.ack got=%h want=%h", obs, exp_v); end
    cycle();
    exp_v = st(0,5,1,0,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL single.svc_hold got=%h want=%h", obs, exp_v); end
    iret = 1'b1; cycle();
    exp_v = st(0,5,0,1,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL single.iret got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_priority();
    irq_in = 8'h44; cycle();
    irq_in = 8'h00; cycle();
    exp_v = st(1,2,0,1,'h44); total++; if (obs !== exp_v) begin bad++; $display("FAIL prio.first got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle();
    exp_v = st(0,2,1,0,'h40); total++; if (obs !== exp_v) begin bad++; $display("FAIL prio.ack1 got=%h want=%h", obs, exp_v); end
    iret = 1'b1; cycle();
    exp_v = st(0,2,0,1,'h40); total++; if (obs !== exp_v) begin bad++; $display("FAIL prio.iret1 got=%h want=%h", obs, exp_v); end
    cycle();
    exp_v = st(1,6,0,1,'h40); total++; if (obs !== exp_v) begin bad++; $display("FAIL prio.second got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle(); iret = 1'b1; cycle();
    exp_v = st(0,6,0,1,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL prio.done got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_masking();
    mask_we = 1'b1; mask_wdata = 8'h01; cycle();
    irq_in = 8'h08; cycle(); irq_in = 8'h00; cycle();
    exp_v = st(0,6,0,1,'h08); total++; if (obs !== exp_v) begin bad++; $display("FAIL mask.blocked got=%h want=%h", obs, exp_v); end
    mask_we = 1'b1; mask_wdata = 8'h08; cycle();
    exp_v = st(0,6,0,1,'h08); total++; if (obs !== exp_v) begin bad++; $display("FAIL mask.latency got=%h want=%h", obs, exp_v); end
    cycle();
    exp_v = st(1,3,0,1,'h08); total++; if (obs !== exp_v) begin bad++; $display("FAIL mask.unmasked got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle(); iret = 1'b1; cycle();
    ie_clr = 1'b1; cycle();
    irq_in = 8'h08; cycle(); irq_in = 8'h00; cycle(); cycle();
    exp_v = st(0,3,0,0,'h08); total++; if (obs !== exp_v) begin bad++; $display("FAIL mask.ie_off got=%h want=%h", obs, exp_v); end
    ie_set = 1'b1; cycle();
    exp_v = st(0,3,0,1,'h08); total++; if (obs !== exp_v) begin bad++; $display("FAIL mask.ie_latency got=%h want=%h", obs, exp_v); end
    cycle();
    exp_v = st(1,3,0,1,'h08); total++; if (obs !== exp_v) begin bad++; $display("FAIL mask.ie_on got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle(); iret = 1'b1; cycle();
  endtask

  task automatic test_committed();
    mask_we = 1'b1; mask_wdata = 8'hFF; cycle();
    irq_in = 8'h10; cycle(); irq_in = 8'h00; cycle();
    exp_v = st(1,4,0,1,'h10); total++; if (obs !== exp_v) begin bad++; $display("FAIL commit.req got=%h want=%h", obs, exp_v); end
    ie_clr = 1'b1; mask_we = 1'b1; mask_wdata = 8'h00; irq_in = 8'h01; cycle();
    exp_v = st(1,4,0,0,'h11); total++; if (obs !== exp_v) begin bad++; $display("FAIL commit.disturb got=%h want=%h", obs, exp_v); end
    irq_in = 8'h00; cycle(); cycle();
    exp_v = st(1,4,0,0,'h11); total++; if (obs !== exp_v) begin bad++; $display("FAIL commit.hold got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle();
    exp_v = st(0,4,1,0,'h01); total++; if (obs !== exp_v) begin bad++; $display("FAIL commit.ack got=%h want=%h", obs, exp_v); end
    iret = 1'b1; cycle(); cycle();
    exp_v = st(0,4,0,1,'h01); total++; if (obs !== exp_v) begin bad++; $display("FAIL commit.masked got=%h want=%h", obs, exp_v); end
    mask_we = 1'b1; mask_wdata = 8'hFF; cycle(); cycle();
    exp_v = st(1,0,0,1,'h01); total++; if (obs !== exp_v) begin bad++; $display("FAIL commit.src0 got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle(); iret = 1'b1; cycle();
  endtask

  task automatic test_simultaneous();
    ie_set = 1'b1; ie_clr = 1'b1; cycle();
    exp_v = st(0,0,0,0,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL simul.set_clr got=%h want=%h", obs, exp_v); end
    ie_set = 1'b1; cycle();
    inta = 1'b1; cycle();
    exp_v = st(0,0,0,1,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL simul.inta_idle got=%h want=%h", obs, exp_v); end
    irq_in = 8'h02; cycle(); irq_in = 8'h00; cycle();
    exp_v = st(1,1,0,1,'h02); total++; if (obs !== exp_v) begin bad++; $display("FAIL simul.req got=%h want=%h", obs, exp_v); end
    irq_in = 8'h02; inta = 1'b1; cycle();
    exp_v = st(0,1,1,0,'h02); total++; if (obs !== exp_v) begin bad++; $display("FAIL simul.set_wins got=%h want=%h", obs, exp_v); end
    irq_in = 8'h00; iret = 1'b1; cycle(); cycle();
    exp_v = st(1,1,0,1,'h02); total++; if (obs !== exp_v) begin bad++; $display("FAIL simul.rereq got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle();
    iret = 1'b1; ie_clr = 1'b1; cycle();
    exp_v = st(0,1,0,0,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL simul.iret_clr got=%h want=%h", obs, exp_v); end
    ie_set = 1'b1; cycle();
  endtask

  task automatic test_reset_mid_service();
    irq_in = 8'h81; cycle(); irq_in = 8'h00; cycle();
    inta = 1'b1; irq_in = 8'h01; cycle();
    exp_v = st(0,0,1,0,'h81); total++; if (obs !== exp_v) begin bad++; $display("FAIL rstsvc.in_service got=%h want=%h", obs, exp_v); end
    irq_in = 8'h00; rst = 1'b1; cycle(); rst = 1'b0;
    exp_v = st(0,0,0,0,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL rstsvc.cleared got=%h want=%h", obs, exp_v); end
    cycle(); cycle();
    mask_we = 1'b1; mask_wdata = 8'hFF; ie_set = 1'b1; cycle(); cycle();
    exp_v = st(0,0,0,1,'h00); total++; if (obs !== exp_v) begin bad++; $display("FAIL rstsvc.quiet got=%h want=%h", obs, exp_v); end
    irq_in = 8'h04; cycle(); irq_in = 8'h00; cycle();
    exp_v = st(1,2,0,1,'h04); total++; if (obs !== exp_v) begin bad++; $display("FAIL rstsvc.new_edge got=%h want=%h", obs, exp_v); end
    inta = 1'b1; cycle(); iret = 1'b1; cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) irq_in = 8'($urandom);
      inta    = ($urandom_range(0, 3) == 0);
      iret    = ($urandom_range(0, 3) == 0);
      ie_set  = ($urandom_range(0, 5) == 0);
      ie_clr  = ($urandom_range(0, 9) == 0);
      mask_we = ($urandom_range(0, 7) == 0);
      mask_wdata = 8'($urandom);
      rst     = ($urandom_range(0, 149) == 0);
      cycle();
      rst = 1'b0;
      exp_v = {m_intp, m_vec, m_insvc, m_ie, m_pending};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL random[%0d] got intp=%b vec=%0d svc=%b ie=%b pend=%h want intp=%b vec=%0d svc=%b ie=%b pend=%h",
                 n, intp, vector, in_service, ie, pending, m_intp, m_vec, m_insvc, m_ie, m_pending);
      end
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    ie_set = 1'b0; ie_clr = 1'b0; inta = 1'b0; iret = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_committed();
    test_simultaneous();
    test_reset_mid_service();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt controller that drives the `intp` request into the processor control unit and completes the acknowledge/return handshake with it. It latches rising edges from up to N_SRC peripheral lines, applies a per-source mask and a global enable, and picks the lowest-index pending source. It holds one request with a stable vector until the control unit acknowledges it, then blocks further requests until return-from-interrupt. It sits between the peripherals and `controlUnit_up`.

## Interface
- N_SRC, default 8: number of interrupt sources (2..32).
- VEC_W, default 3: vector width, equal to clog2(N_SRC).

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  N_SRC  peripheral request lines; a rising edge marks a request.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  N_SRC  new mask value; 1 = source enabled.
- ie_set  in  1  EI pulse from the control unit; sets the global enable.
- ie_clr  in  1  DI pulse from the control unit; clears the global enable.
- inta  in  1  acknowledge pulse from the control unit in the interrupt-fetch state.
- iret  in  1  return-from-interrupt pulse from the control unit.
- intp  out  1  interrupt request to the control unit.
- vector  out  VEC_W  index of the requested source, stable while intp=1.
- in_service  out  1  high from acknowledge until iret.
- pending  out  N_SRC  pending latch contents, for status reads.
- ie  out  1  global enable state.

## Operation
- Edge detection:
  - irq_q registers irq_in each cycle.
  - Bit i sets when irq_in[i] & ~irq_q[i].
  - irq_q resets to 0, so a line already high at reset counts as an edge on the first cycle after reset.
- Pending bits clear only on acknowledge of that source. If a new edge and the clear hit the same bit in the same cycle, the set wins.
- Masking applies to selection only. Masked sources still latch pending.
- Eligible set = pending & mask. Priority is the lowest index.
- FSM has three states:
  - IDLE: if ie=1 and the eligible set is non-empty, latch vector = lowest eligible index, set intp=1, go to REQ.
  - REQ: the request is committed. intp and vector stay frozen regardless of mask writes, ie_clr, or new edges. On inta:
    - clear pending[vector];
    - intp=0, ie=0, in_service=1;
    - go to SERVICE.
  - SERVICE: ignore all requests. On iret: ie=1, in_service=0, go to IDLE.
- ie_set and ie_clr in the same cycle: clear wins. Both act in any state. An ie change in SERVICE has no effect on exit, because iret forces ie=1.
- iret in the same cycle as ie_clr: ie ends at 0.
- inta outside REQ and iret outside SERVICE are ignored.
- mask_we loads mask in any state. The new value is used from the next cycle.
- Reset values: intp=0, vector=0, in_service=0, pending=0, mask=0 (all disabled), ie=0, state=IDLE.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Request latency: irq_in rises before edge k, pending bit visible after edge k, intp=1 after edge k+1. That is 2 cycles with mask=1 and ie=1.
- inta sampled at edge k: intp=0 and in_service=1 after edge k. intp may not return before edge k+1.
- iret sampled at edge k: IDLE after edge k. If eligible sources remain, intp=1 after edge k+1.
- A mask or ie change becomes effective for the IDLE decision one cycle after its strobe.
- rst mid-operation, in any state: all outputs take their reset values after that edge, and in-flight requests are discarded.

## Test plan
- Reset defaults and single request:
  - Reset, then mask=8'hFF, ie_set, pulse irq_in[5].
  - Expect pending=8'h20 the next cycle, intp=1 with vector=5 one cycle later.
  - inta → intp=0, in_service=1, pending=0, ie=0. iret → ie=1, in_service=0.
- Priority and back-to-back:
  - Raise irq_in[6] and irq_in[2] together.
  - Expect vector=2 first. After inta and iret, vector=6 one cycle after iret.
- Masking and disable:
  - mask=8'h01, edge on irq_in[3] → no intp, pending[3]=1.
  - Write mask=8'h08 → intp with vector=3.
  - Repeat with ie_clr asserted → no intp until ie_set.
- Committed request:
  - In REQ with vector=4, assert ie_clr, write mask=0, raise irq_in[0].
  - Expect intp and vector=4 held until inta, and pending[0] latched.
- Simultaneous events:
  - ie_set+ie_clr together → ie=0.
  - New edge on the acknowledged source during inta → pending bit stays 1.
  - inta while IDLE → no state change.
- Reset mid-service:
  - Assert rst in SERVICE with pending=8'h81.
  - Expect all outputs zero, state IDLE, and no intp after release until a new edge occurs with mask and ie set.
